// File: rtl/mcdf_formatter.sv
// rtl/mcdf_formatter.sv - store-and-forward packet formatter for the MCDF arbiter->formatter link
module mcdf_formatter #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int LENW  = 6
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    output logic            f2a_id_req_o,
    output logic            f2a_ack_o,
    input  logic            a2f_val_i,
    input  logic [1:0]      a2f_id_i,
    input  logic [DW-1:0]   a2f_data_i,
    input  logic [2:0]      a2f_pkglen_sel_i,
    output logic            fmt_req_o,
    input  logic            fmt_grant_i,
    output logic [1:0]      fmt_chid_o,
    output logic [LENW-1:0] fmt_length_o,
    output logic            fmt_val_o,
    output logic [DW-1:0]   fmt_data_o,
    output logic            fmt_start_o,
    output logic            fmt_end_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LENW-1:0] ONE = LENW'(1);

    typedef enum logic [1:0] {IDLE, RECV, REQ, SEND} state_t;

    state_t          state, state_nxt;
    logic [LENW-1:0] rcnt, scnt, len_q;
    logic [LENW-1:0] rcnt_inc, last_idx;
    logic [1:0]      chid_q;
    logic            xfer;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   widx, ridx;

    function automatic logic [LENW-1:0] decode_len(input logic [2:0] sel);
        case (sel)
            3'd0:    return LENW'(4);
            3'd1:    return LENW'(8);
            3'd2:    return LENW'(16);
            default: return LENW'(32);
        endcase
    endfunction

    always_comb begin
        f2a_ack_o = 1'b0;
        case (state)
            IDLE:    f2a_ack_o = f2a_id_req_o & a2f_val_i;
            RECV:    f2a_ack_o = a2f_val_i;
            default: f2a_ack_o = 1'b0;
        endcase
    end

    assign xfer     = a2f_val_i & f2a_ack_o;
    assign rcnt_inc = rcnt + ONE;
    assign last_idx = len_q - ONE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (xfer) state_nxt = RECV;
            RECV: if (xfer && rcnt_inc == len_q) state_nxt = REQ;
            // grant only counts while the request is actually on the bus
            REQ:  if (fmt_req_o && fmt_grant_i) state_nxt = SEND;
            SEND: if (scnt == last_idx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            rcnt         <= '0;
            scnt         <= '0;
            len_q        <= '0;
            chid_q       <= '0;
            f2a_id_req_o <= 1'b0;
            fmt_req_o    <= 1'b0;
        end else begin
            state        <= state_nxt;
            f2a_id_req_o <= (state_nxt == IDLE);
            fmt_req_o    <= (state_nxt == REQ);
            if (state == IDLE && xfer) begin
                chid_q <= a2f_id_i;
                len_q  <= decode_len(a2f_pkglen_sel_i);
            end
            if (xfer) rcnt <= rcnt_inc;
            if (state == SEND) scnt <= scnt + ONE;
            if (state == SEND && state_nxt == IDLE) begin
                rcnt <= '0;
                scnt <= '0;
            end
        end
    end

    assign widx = AW'(rcnt);
    assign ridx = AW'(scnt);

    always_ff @(posedge clk_i) begin
        if (xfer) mem[widx] <= a2f_data_i;
    end

    assign fmt_val_o    = (state == SEND);
    assign fmt_start_o  = fmt_val_o && (scnt == '0);
    assign fmt_end_o    = fmt_val_o && (scnt == last_idx);
    assign fmt_data_o   = fmt_val_o ? mem[ridx] : '0;
    assign fmt_chid_o   = chid_q;
    assign fmt_length_o = len_q;

endmodule
